// File: rtl/vertex_transform_pipe_if.sv
// Primitive in/out bus for vertex_transform_pipe: upstream primitive handshake
// plus downstream result handshake. slave = transform block, master = its driver.
interface vertex_transform_pipe_if #(
  parameter int DATA_W = 32,
  parameter int N_VERT = 3
);
  logic                       s_valid;
  logic                       s_ready;
  logic [N_VERT*3*DATA_W-1:0] s_vert;
  logic [9*DATA_W-1:0]        s_mtx;
  logic [3*DATA_W-1:0]        s_trans;
  logic                       m_valid;
  logic                       m_ready;
  logic [N_VERT*3*DATA_W-1:0] m_vert;
  logic                       m_ovf;

  modport slave (
    input  s_valid, s_vert, s_mtx, s_trans, m_ready,
    output s_ready, m_valid, m_vert, m_ovf
  );

  modport master (
    output s_valid, s_vert, s_mtx, s_trans, m_ready,
    input  s_ready, m_valid, m_vert, m_ovf
  );
endinterface

// File: rtl/vertex_transform_pipe.sv
// Affine vertex transform v' = M*v + t using one shared two-stage dot-product unit.
// Define TRANSFORM_SATURATE_EN to clamp out-of-range results instead of wrapping.
module vertex_transform_pipe #(
  parameter int DATA_W  = 32,
  parameter int FRAC_W  = 16,
  parameter int TRUNC_W = 4,
  parameter int N_VERT  = 3
) (
  input  logic                   clk,
  input  logic                   rstn,
  vertex_transform_pipe_if.slave bus,
  output logic                   busy
);
  localparam int OP_W  = DATA_W - TRUNC_W;
  localparam int OP2_W = 2 * OP_W;
  localparam int SUM_W = OP2_W + 2;
  localparam int SHIFT = FRAC_W - 2 * TRUNC_W;
  localparam int VI_W  = (N_VERT > 1) ? $clog2(N_VERT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;

  logic [VI_W-1:0] vert;
  logic [1:0]      row;
  logic            accept, issue, last;

  logic signed [DATA_W-1:0] vert_q [N_VERT][3];
  logic signed [DATA_W-1:0] mtx_q  [3][3];
  logic signed [DATA_W-1:0] trans_q[3];
  logic signed [DATA_W-1:0] res_q  [N_VERT][3];

  logic signed [OP_W-1:0]   ma[3], va[3];
  logic signed [OP2_W-1:0]  prod[3], p_q[3];
  logic signed [DATA_W-1:0] t_q;
  logic                     s1_valid;
  logic [VI_W-1:0]          s1_vert;
  logic [1:0]               s1_row;

  logic signed [SUM_W-1:0]  sum, shifted, full;
  logic                     in_range;
  logic [DATA_W-1:0]        result;

  assign accept = (state == IDLE) && bus.s_valid && bus.s_ready;
  assign issue  = (state == RUN);
  assign last   = (vert == VI_W'(N_VERT - 1)) && (row == 2'd2);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      bus.s_ready <= 1'b0;
      bus.m_valid <= 1'b0;
      busy        <= 1'b0;
      vert        <= '0;
      row         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state       <= RUN;
            bus.s_ready <= 1'b0;
            busy        <= 1'b1;
            vert        <= '0;
            row         <= '0;
          end else begin
            bus.s_ready <= 1'b1;
          end
        end
        RUN: begin
          if (last) begin
            state <= DRAIN;
          end else if (row == 2'd2) begin
            row  <= '0;
            vert <= vert + 1'b1;
          end else begin
            row <= row + 1'b1;
          end
        end
        DRAIN: begin
          state       <= DONE;
          bus.m_valid <= 1'b1;
        end
        DONE: begin
          if (bus.m_ready) begin
            state       <= IDLE;
            bus.m_valid <= 1'b0;
            bus.s_ready <= 1'b1;
            busy        <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 1 operands: truncate LSBs so the product fits 2*(DATA_W-TRUNC_W) bits
  always_comb begin
    for (int unsigned j = 0; j < 3; j++) begin
      ma[j]   = OP_W'(mtx_q[row][j] >>> TRUNC_W);
      va[j]   = OP_W'(vert_q[vert][j] >>> TRUNC_W);
      prod[j] = OP2_W'(ma[j]) * OP2_W'(va[j]);
    end
  end

  always_comb begin
    sum      = SUM_W'(p_q[0]) + SUM_W'(p_q[1]) + SUM_W'(p_q[2]);
    shifted  = sum >>> SHIFT;
    full     = shifted + SUM_W'(t_q);
    in_range = (&full[SUM_W-1:DATA_W-1]) | ~(|full[SUM_W-1:DATA_W-1]);
`ifdef TRANSFORM_SATURATE_EN
    if (in_range)
      result = full[DATA_W-1:0];
    else if (full[SUM_W-1])
      result = {1'b1, {(DATA_W-1){1'b0}}};
    else
      result = {1'b0, {(DATA_W-1){1'b1}}};
`else
    result = full[DATA_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid  <= 1'b0;
      s1_vert   <= '0;
      s1_row    <= '0;
      t_q       <= '0;
      bus.m_ovf <= 1'b0;
      for (int unsigned j = 0; j < 3; j++) begin
        p_q[j]     <= '0;
        trans_q[j] <= '0;
        for (int unsigned c = 0; c < 3; c++) mtx_q[j][c] <= '0;
      end
      for (int unsigned i = 0; i < N_VERT; i++)
        for (int unsigned c = 0; c < 3; c++) begin
          vert_q[i][c] <= '0;
          res_q[i][c]  <= '0;
        end
    end else begin
      if (accept) begin
        bus.m_ovf <= 1'b0;
        for (int unsigned r = 0; r < 3; r++) begin
          trans_q[r] <= bus.s_trans[(2-r)*DATA_W +: DATA_W];
          for (int unsigned c = 0; c < 3; c++)
            mtx_q[r][c] <= bus.s_mtx[(8-(r*3+c))*DATA_W +: DATA_W];
        end
        for (int unsigned i = 0; i < N_VERT; i++)
          for (int unsigned c = 0; c < 3; c++)
            vert_q[i][c] <= bus.s_vert[(N_VERT-1-i)*3*DATA_W + (2-c)*DATA_W +: DATA_W];
      end
      s1_valid <= issue;
      if (issue) begin
        p_q     <= prod;
        t_q     <= trans_q[row];
        s1_vert <= vert;
        s1_row  <= row;
      end
      if (s1_valid) begin
        res_q[s1_vert][s1_row] <= result;
        if (!in_range) bus.m_ovf <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.m_vert = '0;
    for (int unsigned i = 0; i < N_VERT; i++)
      for (int unsigned c = 0; c < 3; c++)
        bus.m_vert[(N_VERT-1-i)*3*DATA_W + (2-c)*DATA_W +: DATA_W] = res_q[i][c];
  end
endmodule

// File: doc/vertex_transform_pipe.md
# vertex_transform_pipe

Sequential fixed-point affine transform engine: applies a 3×3 matrix plus a translation to every vertex of a primitive, v' = M·v + t. It sits in the renderer between the scene fetch and the camera/projection stages. It replaces per-vertex combinational dot products with one shared, pipelined dot-product unit that is time-multiplexed over components and vertices. Vertex count, word width and fixed-point format are parameters.

## Interface
- DATA_W, 32, signed fixed-point word width of all operands and results
- FRAC_W, 16, fractional bits (Q(DATA_W−FRAC_W).FRAC_W)
- TRUNC_W, 4, operand LSBs dropped before multiply; constraint 2·TRUNC_W ≤ FRAC_W
- N_VERT, 3, vertices per primitive; must be ≥ 1
- clk  in  1  system clock, all logic on rising edge
- rstn  in  1  synchronous active-low reset
- s_valid  in  1  input primitive valid
- s_ready  out  1  block can accept a primitive
- s_vert  in  N_VERT·3·DATA_W  vertices, vertex 0 at MSB, each {x,y,z} with x at MSB
- s_mtx  in  9·DATA_W  row-major {R11,R12,R13,R21,…,R33}, R11 at MSB
- s_trans  in  3·DATA_W  {tx,ty,tz}, tx at MSB
- m_valid  out  1  transformed primitive valid
- m_ready  in  1  downstream accepts
- m_vert  out  N_VERT·3·DATA_W  result, same packing as s_vert
- m_ovf  out  1  at least one component exceeded DATA_W range in this primitive
- busy  out  1  high in any state but IDLE

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: s_ready=1. On s_valid&&s_ready, register s_vert, s_mtx and s_trans, clear the issue counter and ovf accumulator, then go to RUN.
- RUN: issue index k = 0…3·N_VERT−1, one per cycle. Vertex = k/3. Row = k%3, giving x', y', z' in that order. At k = 3·N_VERT−1, go to DRAIN.
- DRAIN: one cycle, then DONE.
- DONE: m_valid=1. On m_ready, go to IDLE. s_ready=0 in every state except IDLE.
- Stage 1 (registered):
  - Each operand is arithmetically shifted right by TRUNC_W (truncation, no rounding).
  - The three products are formed at 2·(DATA_W−TRUNC_W) bits signed.
- Stage 2 (registered):
  - Sum the three products at 2·(DATA_W−TRUNC_W)+2 bits.
  - Arithmetic shift right by FRAC_W−2·TRUNC_W.
  - Add the sign-extended translation component.
  - Range-check against DATA_W signed, then write the result into the output slot for (vertex, row).
- m_ovf is the OR of all range violations of the current primitive. It is cleared on input accept.
- m_vert and m_ovf are stable while m_valid=1.

## Timing
- Reset (rstn=0 at a rising edge) has these effects:
  - State goes to IDLE.
  - m_valid=0, s_ready=1 one edge after reset deasserts (s_ready=0 while rstn=0), busy=0.
  - m_vert=0, m_ovf=0, counters=0.
  - Pipeline contents are discarded. A reset mid-RUN/DRAIN/DONE drops the primitive with no m_valid pulse.
- Throughput and latency:
  - Issue k enters stage 1 on the edge after issue and is written to m_vert at edge k+2 relative to issue.
  - m_valid rises at the (3·N_VERT+1)th rising edge after the accepting edge: 10 edges for N_VERT=3.
  - Next accept is possible no earlier than the cycle after the m_valid&&m_ready edge.
- Backpressure: m_ready low holds DONE indefinitely. Outputs must not change and s_ready stays 0.
- s_valid while busy is ignored. The upstream holds it per the valid/ready protocol.
- m_ready high outside DONE has no effect.

## Configuration
- TRANSFORM_SATURATE_EN defined:
  - An out-of-range result clamps to 2^(DATA_W−1)−1 or −2^(DATA_W−1).
  - m_ovf is set.
- Not defined:
  - The result wraps (low DATA_W bits kept).
  - m_ovf is still set.
  - The saturation comparators are removed.

## Test plan
- Defaults, M=identity (diag 0x00010000), v0=(0x10000,0x20000,0x30000), t=(0x8000,0,0xFFFF0000) -> v0'=(0x18000,0x20000,0x20000), m_ovf=0, m_valid 10 edges after accept.
- M=Rz(90°) rows {0,0xFFFF0000,0},{0x10000,0,0},{0,0,0x10000}, v0=(1.0,2.0,3.0), t=0 -> (0xFFFE0000,0x00010000,0x00030000).
- M=identity, v0.x=0x0000000F, t=0 -> x'=0 (TRUNC_W truncation). v1.x=0xFFFFFFF0 -> x'=0xFFFFFFF0.
- M=diag 2.0, v0.x=0x4E200000 (20000.0) -> with TRANSFORM_SATURATE_EN x'=0x7FFFFFFF, m_ovf=1. Without it, x'=0x9C400000, m_ovf=1.
- Hold m_ready=0 for 20 cycles after m_valid -> m_valid, m_vert, m_ovf unchanged and s_ready=0. Then raise m_ready -> one handshake, and s_ready=1 next cycle.
- Assert rstn=0 for 1 cycle at issue k=4 -> IDLE, m_vert=0, m_valid never pulses. A new primitive is then processed correctly with full latency.
